// File: rtl/camera_capture.sv
// camera_capture
// Sensor-side capture front end for DVP cameras (OV7670 class). Samples the
// parallel byte bus on p_clock and assembles BYTES_PER_PIXEL beats into one
// pixel word, with the first byte in the MSBs. Each pixel is tagged with its
// column and row. The block also produces registered framing pulses, skips
// frames when capture_en is low at frame start, and flags frames whose
// geometry differs from H_ACTIVE x V_ACTIVE.
//
// Ports
//   p_clock      in   sensor pixel clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   vsync        in   sensor VSYNC, high = vertical blanking
//   href         in   sensor HREF, high = active bytes on p_data
//   p_data       in   sensor data bus [DATA_W]
//   capture_en   in   frame enable, sampled only at frame start
//   pixel_data   out  assembled pixel [PIX_W], valid with pixel_valid
//   pixel_valid  out  one-cycle strobe for pixel_data/pixel_x/pixel_y
//   pixel_x      out  column of the pixel [COL_W]
//   pixel_y      out  row of the pixel [ROW_W]
//   frame_start  out  one-cycle pulse, a captured frame begins
//   line_done    out  one-cycle pulse at the end of each captured line
//   frame_done   out  one-cycle pulse at the end of each captured frame
//   frame_err    out  geometry error of the last completed frame
//   frame_count  out  number of completed captured frames (wraps)
//
// States
//   state      | meaning
//   ST_SYNC    | after reset, wait for blanking so a partial frame is never captured
//   ST_WAIT    | in blanking, decide at the vsync fall whether to capture or skip
//   ST_SKIP    | frame not captured, ignore the bus until the next blanking
//   ST_ACTIVE  | capturing pixels of the current frame
module camera_capture #(
    parameter int DATA_W          = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    localparam int PIX_W = DATA_W * BYTES_PER_PIXEL,
    localparam int COL_W = $clog2(H_ACTIVE + 1),
    localparam int ROW_W = $clog2(V_ACTIVE + 1)
) (
    input  logic              p_clock,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [DATA_W-1:0] p_data,
    input  logic              capture_en,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_valid,
    output logic [COL_W-1:0]  pixel_x,
    output logic [ROW_W-1:0]  pixel_y,
    output logic              frame_start,
    output logic              line_done,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       frame_count
);

    localparam int PH_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BYTES_PER_PIXEL - 1);
    localparam logic [COL_W-1:0] H_MAX   = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_MAX   = ROW_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_WAIT,
        ST_SKIP,
        ST_ACTIVE
    } state_t;

    state_t            state, state_nx;
    logic              href_q;
    logic [PH_W-1:0]   phase, phase_nx;
    logic [COL_W-1:0]  col, col_nx;
    logic [ROW_W-1:0]  row, row_nx;
    logic              err_acc, err_acc_nx;
    logic [PIX_W-1:0]  pix_sr, pix_sr_nx;

    logic [PIX_W-1:0]  pixel_data_nx;
    logic              pixel_valid_nx;
    logic [COL_W-1:0]  pixel_x_nx;
    logic [ROW_W-1:0]  pixel_y_nx;
    logic              frame_start_nx;
    logic              line_done_nx;
    logic              frame_done_nx;
    logic              frame_err_nx;
    logic [15:0]       frame_count_nx;
    logic              line_close;

    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SYNC;
            href_q      <= 1'b0;
            phase       <= '0;
            col         <= '0;
            row         <= '0;
            err_acc     <= 1'b0;
            pix_sr      <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nx;
            href_q      <= href;
            phase       <= phase_nx;
            col         <= col_nx;
            row         <= row_nx;
            err_acc     <= err_acc_nx;
            pix_sr      <= pix_sr_nx;
            pixel_data  <= pixel_data_nx;
            pixel_valid <= pixel_valid_nx;
            pixel_x     <= pixel_x_nx;
            pixel_y     <= pixel_y_nx;
            frame_start <= frame_start_nx;
            line_done   <= line_done_nx;
            frame_done  <= frame_done_nx;
            frame_err   <= frame_err_nx;
            frame_count <= frame_count_nx;
        end
    end

    // A line closes on the href falling edge, or when vsync rises while the
    // previous cycle was still inside a line.
    assign line_close = (state == ST_ACTIVE) && href_q && (!href || vsync);

    always_comb begin
        state_nx       = state;
        phase_nx       = phase;
        col_nx         = col;
        row_nx         = row;
        err_acc_nx     = err_acc;
        pix_sr_nx      = pix_sr;
        pixel_data_nx  = pixel_data;
        pixel_valid_nx = 1'b0;
        pixel_x_nx     = pixel_x;
        pixel_y_nx     = pixel_y;
        frame_start_nx = 1'b0;
        line_done_nx   = 1'b0;
        frame_done_nx  = 1'b0;
        frame_err_nx   = frame_err;
        frame_count_nx = frame_count;

        case (state)
            ST_SYNC: begin
                if (vsync) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!vsync) begin
                    if (capture_en) begin
                        state_nx       = ST_ACTIVE;
                        frame_start_nx = 1'b1;
                        row_nx         = '0;
                        col_nx         = '0;
                        phase_nx       = '0;
                        err_acc_nx     = 1'b0;
                    end else begin
                        state_nx = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (vsync) state_nx = ST_WAIT;
            end
            ST_ACTIVE: begin
                if (line_close) begin
                    line_done_nx = 1'b1;
                    if (col != H_MAX || phase != '0) err_acc_nx = 1'b1;
                    col_nx   = '0;
                    phase_nx = '0;
                    if (row < V_MAX) row_nx = row + ROW_W'(1);
                end

                if (vsync) begin
                    // err_acc_nx/row_nx already include the line closed above.
                    state_nx       = ST_WAIT;
                    frame_done_nx  = 1'b1;
                    frame_err_nx   = err_acc_nx | (row_nx != V_MAX);
                    frame_count_nx = frame_count + 16'd1;
                end else if (href) begin
                    // Truncating the concatenation shifts the new beat in at the
                    // LSBs, so the first beat of a pixel ends up in the MSBs.
                    pix_sr_nx = PIX_W'({pix_sr, p_data});
                    if (row >= V_MAX) err_acc_nx = 1'b1;
                    if (phase == PH_LAST) begin
                        phase_nx = '0;
                        if (col < H_MAX) begin
                            col_nx = col + COL_W'(1);
                            if (row < V_MAX) begin
                                pixel_valid_nx = 1'b1;
                                pixel_data_nx  = pix_sr_nx;
                                pixel_x_nx     = col;
                                pixel_y_nx     = row;
                            end
                        end else begin
                            err_acc_nx = 1'b1;
                        end
                    end else begin
                        phase_nx = phase + PH_W'(1);
                    end
                end
            end
            default: state_nx = ST_SYNC;
        endcase
    end

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;

    logic p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    logic       rst_n;
    logic       vs, hr;
    logic [7:0] pd;
    logic       capture_en;
    logic       sel;

    // DUT a: BYTES_PER_PIXEL=2; DUT b: BYTES_PER_PIXEL=1. The unselected DUT
    // sees idle blanking (vsync=1, href=0).
    logic       a_vsync, a_href, b_vsync, b_href;
    logic [7:0] a_pdata, b_pdata;
    assign a_vsync = sel ? 1'b1 : vs;
    assign a_href  = sel ? 1'b0 : hr;
    assign a_pdata = sel ? 8'h00 : pd;
    assign b_vsync = sel ? vs : 1'b1;
    assign b_href  = sel ? hr : 1'b0;
    assign b_pdata = sel ? pd : 8'h00;

    logic [15:0] a_pixel_data;
    logic        a_pixel_valid, a_frame_start, a_line_done, a_frame_done, a_frame_err;
    logic [2:0]  a_pixel_x;
    logic [1:0]  a_pixel_y;
    logic [15:0] a_frame_count;

    logic [7:0]  b_pixel_data;
    logic        b_pixel_valid, b_frame_start, b_line_done, b_frame_done, b_frame_err;
    logic [2:0]  b_pixel_x;
    logic [1:0]  b_pixel_y;
    logic [15:0] b_frame_count;

    camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(2)) u_dut_a (
        .p_clock(p_clock), .rst_n(rst_n), .vsync(a_vsync), .href(a_href),
        .p_data(a_pdata), .capture_en(capture_en),
        .pixel_data(a_pixel_data), .pixel_valid(a_pixel_valid),
        .pixel_x(a_pixel_x), .pixel_y(a_pixel_y),
        .frame_start(a_frame_start), .line_done(a_line_done),
        .frame_done(a_frame_done), .frame_err(a_frame_err),
        .frame_count(a_frame_count)
    );

    camera_capture #(.DATA_W(8), .BYTES_PER_PIXEL(1), .H_ACTIVE(4), .V_ACTIVE(2)) u_dut_b (
        .p_clock(p_clock), .rst_n(rst_n), .vsync(b_vsync), .href(b_href),
        .p_data(b_pdata), .capture_en(capture_en),
        .pixel_data(b_pixel_data), .pixel_valid(b_pixel_valid),
        .pixel_x(b_pixel_x), .pixel_y(b_pixel_y),
        .frame_start(b_frame_start), .line_done(b_line_done),
        .frame_done(b_frame_done), .frame_err(b_frame_err),
        .frame_count(b_frame_count)
    );

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
    } pix_t;

    pix_t        qa[$];
    pix_t        qb[$];
    pix_t        pa, pb;
    int          a_lines, a_fs, a_fd, a_both;
    int          b_lines, b_fs, b_fd, b_maxx;
    logic        a_err, b_err;
    logic [15:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always @(negedge p_clock) begin
        if (a_pixel_valid) begin
            pa.d = a_pixel_data;
            pa.x = int'(a_pixel_x);
            pa.y = int'(a_pixel_y);
            qa.push_back(pa);
        end
        if (a_line_done) a_lines++;
        if (a_frame_start) a_fs++;
        if (a_line_done && a_frame_done) a_both++;
        if (a_frame_done) begin
            a_fd++;
            a_err = a_frame_err;
            a_cnt = a_frame_count;
        end
        if (b_pixel_valid) begin
            pb.d = {8'h00, b_pixel_data};
            pb.x = int'(b_pixel_x);
            pb.y = int'(b_pixel_y);
            qb.push_back(pb);
            if (pb.x > b_maxx) b_maxx = pb.x;
        end
        if (b_line_done) b_lines++;
        if (b_frame_start) b_fs++;
        if (b_frame_done) begin
            b_fd++;
            b_err = b_frame_err;
            b_cnt = b_frame_count;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        qa.delete(); qb.delete();
        a_lines = 0; a_fs = 0; a_fd = 0; a_both = 0; a_err = 1'bx; a_cnt = 'x;
        b_lines = 0; b_fs = 0; b_fd = 0; b_maxx = -1; b_err = 1'bx; b_cnt = 'x;
    endtask

    function automatic pix_t qa_at(int i);
        pix_t r;
        r.d = 16'hdead; r.x = -1; r.y = -1;
        if (i < qa.size()) r = qa[i];
        return r;
    endfunction

    function automatic pix_t qb_at(int i);
        pix_t r;
        r.d = 16'hdead; r.x = -1; r.y = -1;
        if (i < qb.size()) r = qb[i];
        return r;
    endfunction

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        vs = v; hr = h; pd = d;
        @(negedge p_clock);
    endtask

    task automatic send_line(input int n, inout logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, b);
            b = b + 8'd1;
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_begin();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        repeat (3) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        pix_t       p;
        sel = 1'b0; rst_n = 1'b0; capture_en = 1'b1;
        vs = 1'b0; hr = 1'b0; pd = 8'h00;
        clear_mon();
        repeat (2) @(negedge p_clock);

        // Reset values, then release in the middle of an active frame.
        check("rst_pixel_valid", 32'(a_pixel_valid), 32'd0);
        check("rst_pixel_data", 32'(a_pixel_data), 32'd0);
        check("rst_frame_count", 32'(a_frame_count), 32'd0);
        check("rst_frame_err", 32'(a_frame_err), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, i[1], 8'(i + 1));
        check("midframe_pixels", 32'(qa.size()), 32'd0);
        check("midframe_fs", 32'(a_fs), 32'd0);
        frame_end();
        check("midframe_fd", 32'(a_fd), 32'd0);
        check("midframe_lines", 32'(a_lines), 32'd0);

        // Nominal 4x2 frame, bytes 0x01..0x10.
        clear_mon();
        b = 8'h01;
        step(1'b0, 1'b0, 8'h00);
        check("fs_pulse_hi", 32'(a_frame_start), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("fs_pulse_lo", 32'(a_frame_start), 32'd0);
        send_line(8, b);
        send_line(8, b);
        frame_end();
        check("nom_npix", 32'(qa.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            p = qa_at(i);
            check($sformatf("nom_data%0d", i), 32'(p.d), 32'({8'(2 * i + 1), 8'(2 * i + 2)}));
            check($sformatf("nom_x%0d", i), 32'(p.x), 32'(i % 4));
            check($sformatf("nom_y%0d", i), 32'(p.y), 32'(i / 4));
        end
        check("nom_lines", 32'(a_lines), 32'd2);
        check("nom_fd", 32'(a_fd), 32'd1);
        check("nom_err", 32'(a_err), 32'd0);
        check("nom_cnt", 32'(a_cnt), 32'd1);

        // Short first line: 3 pixels then a full line.
        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(6, b);
        send_line(8, b);
        frame_end();
        check("short_npix", 32'(qa.size()), 32'd7);
        check("short_err", 32'(a_err), 32'd1);
        check("short_cnt", 32'(a_cnt), 32'd2);

        // Odd beat count: trailing byte must not leak into the next line.
        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(7, b);
        send_line(8, b);
        frame_end();
        check("odd_npix", 32'(qa.size()), 32'd7);
        p = qa_at(2);
        check("odd_last_l0", 32'(p.d), 32'h0506);
        p = qa_at(3);
        check("odd_first_l1", 32'(p.d), 32'h0809);
        check("odd_first_l1_x", 32'(p.x), 32'd0);
        check("odd_first_l1_y", 32'(p.y), 32'd1);
        check("odd_err", 32'(a_err), 32'd1);
        check("odd_cnt", 32'(a_cnt), 32'd3);

        // Skipped frame; capture_en rising mid-frame has no effect.
        clear_mon();
        capture_en = 1'b0;
        b = 8'h01;
        frame_begin();
        send_line(8, b);
        capture_en = 1'b1;
        send_line(8, b);
        frame_end();
        check("skip_npix", 32'(qa.size()), 32'd0);
        check("skip_fs", 32'(a_fs), 32'd0);
        check("skip_fd", 32'(a_fd), 32'd0);
        check("skip_lines", 32'(a_lines), 32'd0);
        check("skip_count", 32'(a_frame_count), 32'd3);

        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(8, b);
        send_line(8, b);
        frame_end();
        check("resume_npix", 32'(qa.size()), 32'd8);
        check("resume_err", 32'(a_err), 32'd0);
        check("resume_cnt", 32'(a_cnt), 32'd4);

        // Extra line beyond V_ACTIVE is suppressed and flagged.
        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(8, b);
        send_line(8, b);
        send_line(8, b);
        frame_end();
        check("tall_npix", 32'(qa.size()), 32'd8);
        check("tall_lines", 32'(a_lines), 32'd3);
        check("tall_err", 32'(a_err), 32'd1);
        check("tall_cnt", 32'(a_cnt), 32'd5);

        // vsync rises while href is still high: line and frame close together.
        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(8, b);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, b);
            b = b + 8'd1;
        end
        step(1'b1, 1'b1, 8'hee);
        frame_end();
        check("vhref_npix", 32'(qa.size()), 32'd8);
        check("vhref_both", 32'(a_both), 32'd1);
        check("vhref_lines", 32'(a_lines), 32'd2);
        check("vhref_err", 32'(a_err), 32'd0);
        check("vhref_cnt", 32'(a_cnt), 32'd6);

        // One byte per pixel, 5 beats per line against H_ACTIVE=4.
        sel = 1'b1;
        clear_mon();
        b = 8'h01;
        frame_begin();
        send_line(5, b);
        send_line(5, b);
        frame_end();
        check("bpp1_npix", 32'(qb.size()), 32'd8);
        check("bpp1_maxx", 32'(b_maxx), 32'd3);
        p = qb_at(0);
        check("bpp1_first", 32'(p.d), 32'h01);
        p = qb_at(4);
        check("bpp1_l1_data", 32'(p.d), 32'h06);
        check("bpp1_l1_y", 32'(p.y), 32'd1);
        check("bpp1_err", 32'(b_err), 32'd1);
        check("bpp1_cnt", 32'(b_cnt), 32'd1);
        check("bpp1_a_idle", 32'(qa.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
